// File: rtl/config_regfile.sv
// ---------------------------------------------------------------------------
// config_regfile
//
// Double-banked configuration register file for the VGA pipeline.
// The host writes go into a shadow bank. The active bank drives the
// display logic. The shadow bank is copied into the active bank at a
// frame boundary (vsync) or on an explicit commit command, so that the
// display never sees a half-updated configuration mid-frame.
//
// Each host request goes through a four-step handshake:
//   IDLE -> CAPTURE -> ACK -> RELEASE -> IDLE
// A request produces exactly one write and one ack, however long the
// decoder holds valid high.
//
// Address map:
//   0 .. NREG-1   storable 4-bit registers (shadow bank)
//   NREG .. 14    unmapped: no write, still acked, sets err
//   15            command register, never stored
//                   4'h1 : commit shadow to active now
//                   4'h2 : clear the whole shadow bank
//                   other: no change, still acked, sets err
//
// Optional feature (compile-time macro CFG_READBACK_EN):
//   Adds a registered shadow-bank read port. rd_data has one cycle of
//   latency and returns 0 for addresses outside 0..NREG-1.
//
// Ports:
//   clk          in   system clock, all state changes on its rising edge
//   rst          in   asynchronous active-low reset
//   valid        in   level "write available" from the address decoder
//   address[3:0] in   target register index / command address
//   data[3:0]    in   write value / command code
//   vsync        in   one-cycle frame-boundary pulse
//   rd_addr[3:0] in   readback address     (CFG_READBACK_EN only)
//   rd_data[3:0] out  readback value       (CFG_READBACK_EN only)
//   ack          out  one-cycle write acknowledge
//   active_regs  out  committed image, register i at bits [4i+3:4i]
//   pending      out  shadow has been written since the last commit
//   err          out  sticky error flag, cleared only by reset
// ---------------------------------------------------------------------------
module config_regfile #(
    parameter int NREG = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [3:0]        address,
    input  logic [3:0]        data,
    input  logic              vsync,
`ifdef CFG_READBACK_EN
    input  logic [3:0]        rd_addr,
    output logic [3:0]        rd_data,
`endif
    output logic              ack,
    output logic [4*NREG-1:0] active_regs,
    output logic              pending,
    output logic              err
);

    // One spare bit so that NREG = 16 would still compare correctly.
    localparam logic [4:0] NREG_LIM = 5'(NREG);

    localparam logic [3:0] CMD_ADDR   = 4'hF;
    localparam logic [3:0] CMD_COMMIT = 4'h1;
    localparam logic [3:0] CMD_CLEAR  = 4'h2;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_ACK     = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0] state;
    logic [1:0] state_next;

    // Request latched at the IDLE edge and executed at the CAPTURE edge.
    logic [3:0] cap_addr;
    logic [3:0] cap_data;

    logic [3:0] shadow [NREG];
    logic [3:0] active [NREG];

    logic in_capture;
    logic is_cmd;
    logic do_store;
    logic do_commit_cmd;
    logic do_clear;
    logic do_bad;
    logic do_commit;

    // ------------------------------------------------------------------
    // Handshake sequencing
    // ------------------------------------------------------------------
    // RELEASE waits for valid to drop so that a decoder holding valid
    // high for many cycles still yields one single write.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (valid) state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_ACK;
            S_ACK:     state_next = S_RELEASE;
            S_RELEASE: if (!valid) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cap_addr <= 4'h0;
            cap_data <= 4'h0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && valid) begin
                cap_addr <= address;
                cap_data <= data;
            end
        end
    end

    // ack is decoded from the state rather than registered separately so
    // that an asynchronous reset during ACK drops it in the same instant.
    assign ack = (state == S_ACK);

    // ------------------------------------------------------------------
    // Request decode (only meaningful in CAPTURE)
    // ------------------------------------------------------------------
    always_comb begin
        in_capture    = (state == S_CAPTURE);
        is_cmd        = (cap_addr == CMD_ADDR);
        do_store      = in_capture && ({1'b0, cap_addr} < NREG_LIM);
        do_commit_cmd = in_capture && is_cmd && (cap_data == CMD_COMMIT);
        do_clear      = in_capture && is_cmd && (cap_data == CMD_CLEAR);
        do_bad        = in_capture && !do_store && !do_commit_cmd && !do_clear;
        // A commit command and a vsync commit on the same edge collapse
        // into one copy of the current shadow content.
        do_commit     = do_commit_cmd || (vsync && pending);
    end

    // ------------------------------------------------------------------
    // Shadow bank: host-visible, written by stores and the clear command
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                shadow[i] <= 4'h0;
            end
        end else if (do_clear) begin
            for (int i = 0; i < NREG; i++) begin
                shadow[i] <= 4'h0;
            end
        end else if (do_store) begin
            shadow[cap_addr] <= cap_data;
        end
    end

    // ------------------------------------------------------------------
    // Active bank: loaded only on a commit. Because the copy samples the
    // shadow before this edge's write lands, a vsync coinciding with a
    // store commits the pre-write content and the new value stays pending.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                active[i] <= 4'h0;
            end
        end else if (do_commit) begin
            for (int i = 0; i < NREG; i++) begin
                active[i] <= shadow[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // pending: a new shadow modification always wins over a same-edge
    // commit, since that commit carried the older content.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= 1'b0;
        end else if (do_store || do_clear) begin
            pending <= 1'b1;
        end else if (do_commit) begin
            pending <= 1'b0;
        end
    end

    // err is sticky; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (do_bad) begin
            err <= 1'b1;
        end
    end

    // Flatten the active bank onto the output bus.
    for (genvar g = 0; g < NREG; g++) begin : g_pack
        assign active_regs[4*g +: 4] = active[g];
    end

`ifdef CFG_READBACK_EN
    // Registered shadow readback; unmapped addresses read as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= 4'h0;
        end else if ({1'b0, rd_addr} < NREG_LIM) begin
            rd_data <= shadow[rd_addr];
        end else begin
            rd_data <= 4'h0;
        end
    end
`endif

endmodule

// File: tb/tb_config_regfile.sv
// ---------------------------------------------------------------------------
// tb_config_regfile
//
// Self-checking bench for config_regfile. A transaction-level model keeps
// the shadow/active banks as plain arrays and tracks each host request by
// the edge on which it was accepted; a compare process checks every DUT
// output against that model on each falling clock edge. Directed scenarios
// pin the model with hand-computed values, then a randomized phase mixes
// writes, commands, vsync pulses and asynchronous resets.
//
// NREG is set below 15 so that the unmapped address range NREG..14 exists.
// Define CFG_READBACK_EN to also exercise the readback port.
// ---------------------------------------------------------------------------
module tb_config_regfile;

    localparam int NREG = 12;

    logic              clk;
    logic              rst;
    logic              valid;
    logic [3:0]        address;
    logic [3:0]        data;
    logic              vsync;
    logic              ack;
    logic [4*NREG-1:0] active_regs;
    logic              pending;
    logic              err;
`ifdef CFG_READBACK_EN
    logic [3:0]        rd_addr;
    logic [3:0]        rd_data;
`endif

    int checks = 0;
    int errors = 0;
    int ack_count = 0;
    bit cmp_on = 0;

    config_regfile #(.NREG(NREG)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid       (valid),
        .address     (address),
        .data        (data),
        .vsync       (vsync),
`ifdef CFG_READBACK_EN
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
`endif
        .ack         (ack),
        .active_regs (active_regs),
        .pending     (pending),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: banks as arrays, handshake as "edge of acceptance"
    // ------------------------------------------------------------------
    logic [3:0] m_shadow [NREG];
    logic [3:0] m_active [NREG];
    logic [3:0] m_snap   [NREG];
    bit         m_pending;
    bit         m_err;
    bit         m_ack;
    int         m_edge;
    int         m_acc;
    logic [3:0] m_addr;
    logic [3:0] m_data;
    logic [3:0] m_rd;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                m_shadow[i] = 4'h0;
                m_active[i] = 4'h0;
            end
            m_pending = 0;
            m_err     = 0;
            m_ack     = 0;
            m_edge    = 0;
            m_acc     = -1;
            m_rd      = 4'h0;
        end else begin
            bit commit;
            bit set_pend;
            bit clr_pend;
            m_edge++;
            m_snap   = m_shadow;
            commit   = vsync && m_pending;
            set_pend = 0;
            clr_pend = commit;
`ifdef CFG_READBACK_EN
            if (int'(rd_addr) < NREG) m_rd = m_snap[rd_addr];
            else                      m_rd = 4'h0;
`endif
            // The accepted request takes effect one edge after acceptance.
            if (m_acc >= 0 && m_edge == m_acc + 1) begin
                if (int'(m_addr) < NREG) begin
                    m_shadow[m_addr] = m_data;
                    set_pend = 1;
                end else if (m_addr == 4'hF && m_data == 4'h1) begin
                    commit   = 1;
                    clr_pend = 1;
                end else if (m_addr == 4'hF && m_data == 4'h2) begin
                    for (int i = 0; i < NREG; i++) m_shadow[i] = 4'h0;
                    set_pend = 1;
                end else begin
                    m_err = 1;
                end
            end
            if (commit) m_active = m_snap;
            if (set_pend)      m_pending = 1;
            else if (clr_pend) m_pending = 0;
            // New request only when no request is outstanding; a finished
            // request is retired once valid is seen low from the third edge on.
            if (m_acc < 0) begin
                if (valid) begin
                    m_acc  = m_edge;
                    m_addr = address;
                    m_data = data;
                end
            end else if (m_edge >= m_acc + 3 && !valid) begin
                m_acc = -1;
            end
            m_ack = (m_acc >= 0) && (m_edge == m_acc + 1);
        end
    end

    function automatic logic [4*NREG-1:0] model_image();
        logic [4*NREG-1:0] v;
        for (int i = 0; i < NREG; i++) v[4*i +: 4] = m_active[i];
        return v;
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            check_output("cyc_ack",     64'(ack),         64'(m_ack));
            check_output("cyc_active",  64'(active_regs), 64'(model_image()));
            check_output("cyc_pending", 64'(pending),     64'(m_pending));
            check_output("cyc_err",     64'(err),         64'(m_err));
`ifdef CFG_READBACK_EN
            check_output("cyc_rd_data", 64'(rd_data),     64'(m_rd));
`endif
        end
    end

    always @(negedge clk) begin
        if (ack === 1'b1) ack_count++;
    end

    // One host request; called just after a falling edge with the FSM idle.
    task automatic apply_stimulus(input logic [3:0] a, input logic [3:0] d,
                                  input int hold, input bit vs_on_capture);
        valid   = 1'b1;
        address = a;
        data    = d;
        @(negedge clk);
        check_output("ack_early", 64'(ack), 64'd0);
        if (vs_on_capture) vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        check_output("ack_on_time", 64'(ack), 64'd1);
        repeat (hold - 2) @(negedge clk);
        valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_vsync();
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
    endtask

    logic [4*NREG-1:0] exp_img;

    initial begin
        rst     = 1'b0;
        valid   = 1'b0;
        address = 4'h0;
        data    = 4'h0;
        vsync   = 1'b0;
`ifdef CFG_READBACK_EN
        rd_addr = 4'h0;
`endif
        repeat (3) @(negedge clk);
        check_output("reset_active",  64'(active_regs), 64'd0);
        check_output("reset_ack",     64'(ack),         64'd0);
        check_output("reset_pending", 64'(pending),     64'd0);
        check_output("reset_err",     64'(err),         64'd0);
        rst    = 1'b1;
        cmp_on = 1;
        @(negedge clk);

        // Held valid: single ack, value staged but not yet visible.
        ack_count = 0;
        apply_stimulus(4'd3, 4'hA, 10, 0);
        check_output("hold_one_ack",   64'(ack_count),          64'd1);
        check_output("hold_pending",   64'(pending),            64'd1);
        check_output("hold_not_live",  64'(active_regs[15:12]), 64'h0);
        pulse_vsync();
        check_output("vsync_commit",   64'(active_regs[15:12]), 64'hA);
        check_output("vsync_clr_pend", 64'(pending),            64'd0);

        // Immediate commit command.
        apply_stimulus(4'd0, 4'h5, 2, 0);
        apply_stimulus(4'hF, 4'h1, 2, 0);
        check_output("cmd_commit",     64'(active_regs[3:0]), 64'h5);
        check_output("cmd_commit_pnd", 64'(pending),          64'd0);

        // vsync on the CAPTURE edge commits the pre-write shadow.
        apply_stimulus(4'd2, 4'h4, 2, 0);
        apply_stimulus(4'd2, 4'h7, 2, 1);
        check_output("race_old_value", 64'(active_regs[11:8]), 64'h4);
        check_output("race_pending",   64'(pending),           64'd1);
        pulse_vsync();
        check_output("race_next_vs",   64'(active_regs[11:8]), 64'h7);

        // Bad command: acked, nothing changes, err sticks.
        exp_img        = '0;
        exp_img[3:0]   = 4'h5;
        exp_img[11:8]  = 4'h7;
        exp_img[15:12] = 4'hA;
        apply_stimulus(4'hF, 4'h9, 2, 0);
        check_output("bad_cmd_err",    64'(err),         64'd1);
        check_output("bad_cmd_img",    64'(active_regs), 64'(exp_img));
        check_output("bad_cmd_pend",   64'(pending),     64'd0);
        apply_stimulus(4'd1, 4'h3, 2, 0);
        check_output("err_sticky",     64'(err),         64'd1);
        apply_stimulus(4'hF, 4'h2, 2, 0);
        check_output("clear_img",      64'(active_regs), 64'(exp_img));
        check_output("clear_pend",     64'(pending),     64'd1);
        pulse_vsync();
        check_output("clear_commit",   64'(active_regs), 64'd0);

        // Reset during ACK aborts; held valid afterwards is a new request.
        valid   = 1'b1;
        address = 4'd1;
        data    = 4'h9;
        @(negedge clk);
        @(negedge clk);
        #2 rst  = 1'b0;
        address = 4'd5;
        data    = 4'h6;
        #1;
        check_output("rst_ack_drop", 64'(ack),         64'd0);
        check_output("rst_active",   64'(active_regs), 64'd0);
        check_output("rst_pending",  64'(pending),     64'd0);
        check_output("rst_err",      64'(err),         64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("rel_ack_early", 64'(ack), 64'd0);
        @(negedge clk);
        check_output("rel_ack",       64'(ack), 64'd1);
        valid = 1'b0;
        repeat (3) @(negedge clk);
        pulse_vsync();
        exp_img        = '0;
        exp_img[23:20] = 4'h6;
        check_output("rel_new_write", 64'(active_regs), 64'(exp_img));

        // Address boundaries: NREG is unmapped, NREG-1 is storable.
        apply_stimulus(4'(NREG), 4'h3, 2, 0);
        check_output("bad_addr_err",  64'(err),     64'd1);
        check_output("bad_addr_pend", 64'(pending), 64'd0);
        apply_stimulus(4'(NREG - 1), 4'h6, 2, 0);
        check_output("top_addr_pend", 64'(pending), 64'd1);
        pulse_vsync();
        check_output("top_addr_val",  64'(active_regs[4*NREG-1 -: 4]), 64'h6);

`ifdef CFG_READBACK_EN
        apply_stimulus(4'd4, 4'hC, 2, 0);
        rd_addr = 4'd4;
        @(negedge clk);
        check_output("rd_value", 64'(rd_data), 64'hC);
        rd_addr = 4'hF;
        @(negedge clk);
        check_output("rd_unmapped", 64'(rd_data), 64'h0);
`endif

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            int sel;
            sel   = int'($urandom_range(0, 9));
            valid = ($urandom_range(0, 2) != 0);
            data  = 4'($urandom_range(0, 15));
            if (sel < 6) begin
                address = 4'($urandom_range(0, NREG - 1));
            end else if (sel == 6) begin
                address = 4'hF;
                data    = 4'h1;
            end else if (sel == 7) begin
                address = 4'hF;
                data    = 4'h2;
            end else begin
                address = 4'($urandom_range(NREG, 15));
            end
            vsync = ($urandom_range(0, 5) == 0);
`ifdef CFG_READBACK_EN
            rd_addr = 4'($urandom_range(0, 15));
`endif
            if ($urandom_range(0, 149) == 0) begin
                #2 rst = 1'b0;
                #2 rst = 1'b1;
            end
            @(negedge clk);
        end

        valid = 1'b0;
        vsync = 1'b0;
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
